// File: rtl/cfg_reg_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cfg_reg_loader_pkg
// Brief   : Shared types and register value tables for cfg_reg_loader.
// Revision: 1.0
// ============================================================================
package cfg_reg_loader_pkg;

    typedef enum logic [2:0] {
        adc0_reg         = 3'd0,
        adc1_reg         = 3'd1,
        temp_sensor0_reg = 3'd2,
        temp_sensor1_reg = 3'd3,
        analog_test      = 3'd4,
        digital_test     = 3'd5,
        amp_gain         = 3'd6,
        digital_config   = 3'd7
    } address_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] RESET_VALUE [8] = '{
        16'hFFFF, 16'h0000, 16'h0000, 16'h0000,
        16'hABCD, 16'h0000, 16'h0000, 16'h0001
    };

    localparam logic [15:0] BOOT_VALUE [8] = '{
        16'h1234, 16'h00FF, 16'h0A0A, 16'h0B0B,
        16'h5555, 16'hAAAA, 16'h0010, 16'h8001
    };

endpackage
`default_nettype wire

// File: rtl/cfg_reg_loader_rd_wait.sv
`default_nettype none
// ============================================================================
// Module  : cfg_rd_wait
// Brief   : Read-latency down-counter; o_last flags the compare cycle.
// Revision: 1.0
// ============================================================================
module cfg_rd_wait #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    output logic o_last
);

    logic [2:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 3'd0;
        end else if (i_load) begin
            r_cnt <= 3'(RD_LAT);
        end else if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
        end
    end

    assign o_last = (r_cnt == 3'd0);

endmodule
`default_nettype wire

// File: rtl/cfg_reg_loader.sv
`default_nettype none
// ============================================================================
// Module  : cfg_reg_loader
// Brief   : Programs/verifies the config_reg file and reports a mismatch mask.
// Revision: 1.0
// ============================================================================
module cfg_reg_loader
    import cfg_reg_loader_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_mask,
    output logic        cfg_write,
    output address_t    cfg_address,
    output logic [15:0] cfg_data_in,
    input  logic [15:0] cfg_data_out
);

    state_t      r_state;
    logic [2:0]  r_idx;
    logic        r_mode;

    logic        w_last;
    logic        w_load;
    logic        w_miss;
    logic [2:0]  w_idx_nxt;
    logic [15:0] w_expect;
    logic [7:0]  w_mask_next;

    assign w_idx_nxt   = r_idx + 3'd1;
    assign w_expect    = r_mode ? RESET_VALUE[r_idx] : BOOT_VALUE[r_idx];
    assign w_miss      = w_last && (cfg_data_out != w_expect);
    assign w_mask_next = err_mask | (w_miss ? (8'd1 << r_idx) : 8'd0);

    // Reload the latency counter on every edge that begins a fresh read slot.
    assign w_load = ((r_state == ST_IDLE)  && start && mode) ||
                    ((r_state == ST_WRITE) && (r_idx == 3'd7)) ||
                    ((r_state == ST_READ)  && w_last && (r_idx != 3'd7));

    cfg_rd_wait #(
        .RD_LAT (RD_LAT)
    ) u_rd_wait (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .o_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= 3'd0;
            r_mode      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_mask    <= 8'd0;
            cfg_write   <= 1'b0;
            cfg_address <= adc0_reg;
            cfg_data_in <= 16'd0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_idx       <= 3'd0;
                        r_mode      <= mode;
                        err_mask    <= 8'd0;
                        pass        <= 1'b0;
                        busy        <= 1'b1;
                        cfg_address <= adc0_reg;
                        if (mode) begin
                            r_state   <= ST_READ;
                            cfg_write <= 1'b0;
                        end else begin
                            r_state     <= ST_WRITE;
                            cfg_write   <= 1'b1;
                            cfg_data_in <= BOOT_VALUE[0];
                        end
                    end
                end
                ST_WRITE: begin
                    if (r_idx == 3'd7) begin
                        r_state     <= ST_READ;
                        r_idx       <= 3'd0;
                        cfg_write   <= 1'b0;
                        cfg_address <= adc0_reg;
                    end else begin
                        r_idx       <= w_idx_nxt;
                        cfg_address <= address_t'(w_idx_nxt);
                        cfg_data_in <= BOOT_VALUE[w_idx_nxt];
                    end
                end
                ST_READ: begin
                    if (w_last) begin
                        err_mask <= w_mask_next;
                        if (r_idx == 3'd7) begin
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                            pass    <= (w_mask_next == 8'd0);
                        end else begin
                            r_idx       <= w_idx_nxt;
                            cfg_address <= address_t'(w_idx_nxt);
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/cfg_reg_loader.md
# cfg_reg_loader

Bus initiator for the `config_reg` register file. On a `start` pulse it drives the register interface to do one of two things:
- program all eight registers with boot values, then read each back and compare;
- read each register back and compare against its reset default, with no writes.

It reports a per-register mismatch mask and a one-cycle `done` pulse. It sits between the power-up controller and `config_reg`, and owns the `write`, `address` and `data_in` pins of `config_reg`.

## Interface
- RD_LAT, 1, cycles from address presented (write=0) to valid `cfg_data_out`; legal range 1..4
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request; ignored while `busy`
- mode  in  1  0 = program+verify, 1 = verify reset defaults only
- busy  out  1  high whenever the FSM is not IDLE
- done  out  1  one-cycle pulse at end of sequence
- pass  out  1  `err_mask == 0`; valid when `done` is high, held until next start
- err_mask  out  8  bit i set = mismatch at address i
- cfg_write  out  1  to `config_reg` write
- cfg_address  out  address_t (3)  to `config_reg` address
- cfg_data_in  out  16  to `config_reg` data_in
- cfg_data_out  in  16  from `config_reg` data_out

## Operation
- All outputs are registered.
- Reset values: `busy`, `done`, `cfg_write` = 0; `pass` = 0; `err_mask` = 0; `cfg_address` = adc0_reg; `cfg_data_in` = 0; FSM in IDLE; index = 0.
- FSM states: IDLE, WRITE, READ, DONE.
- IDLE:
  - on `start` with `mode`=0, go to WRITE; with `mode`=1, go to READ.
  - on accepting start: index = 0, `err_mask` = 0, `pass` = 0.
- WRITE (one cycle per register, index 0..7):
  - `cfg_write`=1, `cfg_address`=index, `cfg_data_in`=BOOT_VALUE[index].
  - after index 7, go to READ with index = 0.
- READ (1+RD_LAT cycles per register):
  - `cfg_write`=0, `cfg_address`=index; `cfg_data_in` holds its last value.
  - on the last cycle, compare `cfg_data_out` against the expected value and set `err_mask[index]` if they differ.
  - expected value = BOOT_VALUE[index] when `mode`=0, RESET_VALUE[index] when `mode`=1.
  - after index 7, go to DONE.
- `mode` is latched on start acceptance; changes to the `mode` pin during a sequence have no effect.
- DONE (one cycle): `done`=1, `pass`=(`err_mask`==0), then return to IDLE.
- `cfg_write` is never high outside WRITE.
- `start` asserted in DONE or any busy state is dropped, not queued.
- Reset mid-sequence: next cycle is IDLE with reset values on all outputs; no partial result is reported.

## Timing
Start is sampled at edge E0; cycle n is the cycle following edge En.
- mode 0:
  - WRITE occupies cycles 1..8.
  - READ occupies cycles 9..8+8·(1+RD_LAT).
  - `done` in the following cycle: cycle 25 for RD_LAT=1.
- mode 1:
  - READ occupies cycles 1..8·(1+RD_LAT).
  - `done` at cycle 8·(1+RD_LAT)+1: cycle 17 for RD_LAT=1.
- `busy` is high from cycle 1 through the DONE cycle inclusive.
- A new start is accepted in the cycle after DONE at the earliest.
- Address order is fixed: adc0_reg, adc1_reg, temp_sensor0_reg, temp_sensor1_reg, analog_test, digital_test, amp_gain, digital_config (encodings 0..7).

## Structure
- The shared package holds:
  - `address_t` (the same enum used by `config_reg`).
  - RESET_VALUE[8] = FFFF, 0000, 0000, 0000, ABCD, 0000, 0000, 0001.
  - BOOT_VALUE[8] = 1234, 00FF, 0A0A, 0B0B, 5555, AAAA, 0010, 8001.
  - The state enum for this FSM.
- One natural sub-module: `cfg_rd_wait`, a 3-bit down-counter loaded with RD_LAT that flags the compare cycle.
- Everything else lives in a single FSM module.

## Test plan
- Reset, then start with mode=1 against a freshly reset `config_reg` (RD_LAT=1) → `done` at cycle 17, `err_mask`=00, `pass`=1, `cfg_write` never high.
- Start with mode=0 → exactly 8 write cycles carrying BOOT_VALUE in address order, `done` at cycle 25, `pass`=1; a later mode=1 run gives `err_mask`=FF, except bit 2 stays clear only if BOOT matches reset (it does not, so `err_mask`=FF).
- Model with amp_gain stuck at 0000, run mode=0 → `err_mask`=40, `pass`=0.
- Pulse `start` again at cycle 5 of a mode=0 run, and toggle `mode` mid-run → sequence unaffected, single `done` at cycle 25.
- Assert `reset` at cycle 12 of a mode=0 run → next cycle `busy`=0, `err_mask`=00, `cfg_write`=0; a fresh start then completes normally.
- RD_LAT=3 with a 3-cycle-latency `config_reg` model, mode=1 → `done` at cycle 33, `pass`=1.
